// File: rtl/store_pkg.sv
// Shared types and the lane-merge helper for the read-modify-write store unit.
// Used by store_rmw_unit (optional STORE_FWD_EN write-forwarding) and store_lane_merge.
package store_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } storeSizeT;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StCapture,
        StWrite,
        StErr
    } storeStateT;

    // Insert the halfword/byte of regData into oldWord at the given lane; word replaces all.
    function automatic logic [31:0] laneMerge(input logic [31:0] oldWord,
                                              input logic [31:0] regData,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
        logic [31:0] merged;
        merged = oldWord;
        case (size)
            SZ_WORD: merged = regData;
            SZ_HALF: begin
                if (lane[1]) merged[31:16] = regData[15:0];
                else         merged[15:0]  = regData[15:0];
            end
            SZ_BYTE: merged[{lane, 3'b000} +: 8] = regData[7:0];
            default: merged = oldWord;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: places the store data into the old memory word.
// Shared by the memory-read path and the STORE_FWD_EN forwarding path.
module store_lane_merge
    import store_pkg::*;
(
    input  logic [31:0] oldWord,
    input  logic [31:0] regData,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    assign merged = laneMerge(oldWord, regData, size, lane);

endmodule

// File: rtl/store_rmw_unit.sv
// Read-modify-write store controller for a single-port word-addressed data memory.
// Define STORE_FWD_EN to add a one-entry write buffer that skips the read on a hit.
module store_rmw_unit
    import store_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic [1:0]            StoreSize,
    input  logic [31:0]           Addr,
    input  logic [31:0]           RegData,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic                  MemRE,
    output logic                  MemWE,
    output logic [31:0]           MemWrData,
    input  logic [31:0]           MemRdData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  AlignErr
);

    localparam logic [2:0] WaitInit = 3'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);

    storeStateT            stateQ, stateD;
    logic [ADDR_WIDTH-1:0] idxQ;
    logic [1:0]            laneQ;
    logic [1:0]            sizeQ;
    logic [31:0]           dataQ;
    logic [31:0]           mergeQ;
    logic [2:0]            waitCntQ;
    logic [31:0]           mergedWord;

    logic [ADDR_WIDTH-1:0] reqIdx;
    logic                  accept;
    logic                  illegal;
    logic                  subWord;
    logic                  fwdHit;
    logic [31:0]           fwdData;
    logic                  unusedAddr;

    // Upper address bits beyond the memory are intentionally dropped (wrap-around).
    assign reqIdx     = Addr[ADDR_WIDTH+1:2];
    assign unusedAddr = ^Addr[31:ADDR_WIDTH+2];
    assign accept     = ReqValid && ReqReady;
    assign subWord    = (StoreSize == SZ_HALF) || (StoreSize == SZ_BYTE);
    assign illegal    = (StoreSize == SZ_RSVD)
                     || ((StoreSize == SZ_WORD) && (Addr[1:0] != 2'b00))
                     || ((StoreSize == SZ_HALF) && Addr[0]);

`ifdef STORE_FWD_EN
    logic                  fwdValidQ;
    logic [ADDR_WIDTH-1:0] fwdIdxQ;
    logic [31:0]           fwdDataQ;

    assign fwdHit  = fwdValidQ && (fwdIdxQ == reqIdx);
    assign fwdData = fwdDataQ;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fwdValidQ <= 1'b0;
            fwdIdxQ   <= '0;
            fwdDataQ  <= '0;
        end else if (stateQ == StWrite) begin
            fwdValidQ <= 1'b1;
            fwdIdxQ   <= idxQ;
            fwdDataQ  <= mergedWord;
        end
    end
`else
    assign fwdHit  = 1'b0;
    assign fwdData = '0;
`endif

    store_lane_merge uMerge (
        .oldWord (mergeQ),
        .regData (dataQ),
        .size    (sizeQ),
        .lane    (laneQ),
        .merged  (mergedWord)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) stateQ <= StIdle;
        else      stateQ <= stateD;
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (accept) begin
                    if (illegal)                stateD = StErr;
                    else if (!subWord || fwdHit) stateD = StWrite;
                    else                        stateD = StRead;
                end
            end
            StRead:    stateD = (READ_LATENCY == 1) ? StCapture : StWait;
            StWait:    stateD = (waitCntQ == 3'd0) ? StCapture : StWait;
            StCapture: stateD = StWrite;
            StWrite:   stateD = StIdle;
            StErr:     stateD = StIdle;
            default:   stateD = StIdle;
        endcase
    end

    always_comb begin
        ReqReady  = (stateQ == StIdle);
        Busy      = (stateQ != StIdle);
        MemAddr   = '0;
        MemRE     = 1'b0;
        MemWE     = 1'b0;
        MemWrData = '0;
        Done      = 1'b0;
        AlignErr  = 1'b0;
        unique case (stateQ)
            StRead: begin
                MemRE   = 1'b1;
                MemAddr = idxQ;
            end
            StWrite: begin
                MemWE     = 1'b1;
                MemAddr   = idxQ;
                MemWrData = mergedWord;
                Done      = 1'b1;
            end
            StErr:   AlignErr = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            idxQ     <= '0;
            laneQ    <= '0;
            sizeQ    <= '0;
            dataQ    <= '0;
            mergeQ   <= '0;
            waitCntQ <= '0;
        end else begin
            if (accept) begin
                idxQ  <= reqIdx;
                laneQ <= Addr[1:0];
                sizeQ <= StoreSize;
                dataQ <= RegData;
                if (fwdHit) mergeQ <= fwdData;
            end
            if (stateQ == StRead)    waitCntQ <= WaitInit;
            if (stateQ == StWait)    waitCntQ <= waitCntQ - 3'd1;
            if (stateQ == StCapture) mergeQ   <= MemRdData;
        end
    end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Scoreboard bench for store_rmw_unit: directed cases then randomized stores vs. a memory model.
// Expected latencies follow STORE_FWD_EN when the bench is built with that macro.
module tb_store_rmw_unit;

    localparam int AW = 10;
    localparam int RL = 1;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          ReqValid = 1'b0;
    logic          ReqReady;
    logic [1:0]    StoreSize = 2'b00;
    logic [31:0]   Addr = 32'h0;
    logic [31:0]   RegData = 32'h0;
    logic [AW-1:0] MemAddr;
    logic          MemRE;
    logic          MemWE;
    logic [31:0]   MemWrData;
    logic [31:0]   MemRdData;
    logic          Busy;
    logic          Done;
    logic          AlignErr;

    store_rmw_unit #(
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (RL)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .StoreSize (StoreSize),
        .Addr      (Addr),
        .RegData   (RegData),
        .MemAddr   (MemAddr),
        .MemRE     (MemRE),
        .MemWE     (MemWE),
        .MemWrData (MemWrData),
        .MemRdData (MemRdData),
        .Busy      (Busy),
        .Done      (Done),
        .AlignErr  (AlignErr)
    );

    always #5 Clk = ~Clk;

    // Memory with READ_LATENCY-deep read pipeline; the only writer is the DUT.
    logic [31:0] mem [0:(1<<AW)-1] = '{default: 32'h0};
    logic [31:0] rdPipe [0:RL-1] = '{default: 32'h0};
    assign MemRdData = rdPipe[RL-1];

    always @(posedge Clk) begin
        if (MemWE) mem[MemAddr] <= MemWrData;
        rdPipe[0] <= MemRE ? mem[MemAddr] : 32'h0BAD0BAD;
        for (int i = 1; i < RL; i++) rdPipe[i] <= rdPipe[i-1];
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model state: memory contents and the forwarding buffer's tag.
    typedef struct {
        bit          isErr;
        bit          expRead;
        logic [9:0]  idx;
        logic [31:0] data;
        int          due;
    } expT;

    expT         sbq[$];
    logic [31:0] refMem [0:(1<<AW)-1] = '{default: 32'h0};
    bit          fwdValid = 1'b0;
    logic [9:0]  fwdIdx = '0;

    function automatic expT predict(input logic [1:0] sz, input logic [31:0] a,
                                    input logic [31:0] d, input int c0);
        expT         e;
        logic [31:0] old;
        logic [31:0] mask;
        int          sh;
        bit          hit;
        e.idx = a[11:2];
        e.isErr = (sz == 2'b11) || (sz == 2'b00 && a[1:0] != 2'b00) || (sz == 2'b01 && a[0]);
        e.expRead = 1'b0;
        e.data = 32'h0;
        e.due = c0 + 1;
        if (!e.isErr) begin
            old = refMem[e.idx];
            if (sz == 2'b00) begin
                e.data = d;
            end else begin
                sh = (sz == 2'b01) ? (a[1] ? 16 : 0) : 8 * int'(a[1:0]);
                mask = ((sz == 2'b01) ? 32'h0000FFFF : 32'h000000FF) << sh;
                e.data = (old & ~mask) | ((d << sh) & mask);
            end
`ifdef STORE_FWD_EN
            hit = fwdValid && (fwdIdx == e.idx);
`else
            hit = 1'b0;
`endif
            e.expRead = (sz != 2'b00) && !hit;
            e.due = c0 + (e.expRead ? 2 + RL : 1);
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT writes or flags an error.
    always @(negedge Clk) begin
        if (Rst) begin
            if (MemRE && MemWE) failNow("re_we_overlap");
            chk("done_eq_we", 32'(Done), 32'(MemWE));
            if (MemRE) begin
                if (sbq.size() == 0 || !sbq[0].expRead) failNow("unexpected_read");
                else chk("read_addr", 32'(MemAddr), 32'(sbq[0].idx));
            end
            if (MemWE || AlignErr) begin
                if (sbq.size() == 0) begin
                    failNow("unexpected_output");
                end else begin
                    expT e;
                    e = sbq.pop_front();
                    chk("kind_err", 32'(AlignErr), 32'(e.isErr));
                    chk("latency", cyc, e.due);
                    if (!e.isErr) begin
                        chk("write_addr", 32'(MemAddr), 32'(e.idx));
                        chk("write_data", MemWrData, e.data);
                    end
                end
            end
        end
    end

    // Present a request (held until accepted); returns #1 into the cycle after the accept.
    task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                         input bit dropAfter);
        int  waited;
        expT e;
        waited = 0;
        ReqValid = 1'b1;
        StoreSize = sz;
        Addr = a;
        RegData = d;
        while (!ReqReady && waited < 50) begin
            @(posedge Clk); #1;
            waited++;
        end
        if (!ReqReady) begin
            failNow("accept_timeout");
            ReqValid = 1'b0;
            return;
        end
        e = predict(sz, a, d, cyc);
        sbq.push_back(e);
        if (!e.isErr) begin
            refMem[e.idx] = e.data;
            fwdValid = 1'b1;
            fwdIdx = e.idx;
        end
        @(posedge Clk); #1;
        if (dropAfter) ReqValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge Clk); #1;
            n++;
        end
        if (sbq.size() != 0) begin
            failNow("drain_timeout");
            sbq.delete();
        end
    endtask

    logic [31:0] laneExp [0:3];
    logic [31:0] saved;

    initial begin
        laneExp[0] = 32'h112233EE;
        laneExp[1] = 32'h1122EE44;
        laneExp[2] = 32'h11EE3344;
        laneExp[3] = 32'hEE223344;

        #2;
        chk("rst_ready", 32'(ReqReady), 32'd1);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_re", 32'(MemRE), 32'd0);
        chk("rst_we", 32'(MemWE), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_alignerr", 32'(AlignErr), 32'd0);
        chk("rst_memaddr", 32'(MemAddr), 32'd0);
        chk("rst_wrdata", MemWrData, 32'd0);
        @(posedge Clk); @(posedge Clk); #1;
        Rst = 1'b1;
        @(posedge Clk); #1;

        // Word store, then a sub-word store on a fresh buffer tag with Busy timing.
        issue(2'b00, 32'h10, 32'hDEADBEEF, 1'b1);
        drain();
        issue(2'b00, 32'h10, 32'h11223344, 1'b1);
        issue(2'b00, 32'h40, 32'h55667788, 1'b1);
        drain();
        issue(2'b01, 32'h12, 32'h0000ABCD, 1'b1);
        chk("sh_busy_c1", 32'(Busy), 32'd1);
        chk("sh_re_c1", 32'(MemRE), 32'd1);
        @(posedge Clk); #1;
        chk("sh_busy_c2", 32'(Busy), 32'd1);
        @(posedge Clk); #1;
        chk("sh_busy_c3", 32'(Busy), 32'd1);
        chk("sh_we_c3", 32'(MemWE), 32'd1);
        @(posedge Clk); #1;
        chk("sh_busy_c4", 32'(Busy), 32'd0);
        drain();

        // Every byte lane of a known word.
        for (int l = 0; l < 4; l++) begin
            issue(2'b00, 32'h10, 32'h11223344, 1'b1);
            issue(2'b10, 32'h10 + 32'(l), 32'h000000EE, 1'b1);
            drain();
            chk("byte_lane_mem", mem[4], laneExp[l]);
        end

        // Illegal requests: misaligned half, reserved size, misaligned word.
        issue(2'b01, 32'h13, 32'h1234, 1'b1);
        @(posedge Clk); #1;
        chk("err_ready_c2", 32'(ReqReady), 32'd1);
        issue(2'b11, 32'h10, 32'h1234, 1'b1);
        issue(2'b00, 32'h12, 32'h1234, 1'b1);
        drain();

        // Forwarding case: sh right after sw to the same word.
        issue(2'b00, 32'h10, 32'hDEADBEEF, 1'b0);
        issue(2'b01, 32'h10, 32'h00001234, 1'b1);
        drain();
        chk("fwd_mem", mem[4], 32'hDEAD1234);

        // Reset while a half store is in flight: no write, all outputs idle.
        issue(2'b00, 32'h20, 32'hCAFEF00D, 1'b1);
        drain();
        saved = refMem[8];
        issue(2'b00, 32'h40, 32'h0, 1'b1);
        drain();
        issue(2'b01, 32'h22, 32'h00009999, 1'b1);
        @(posedge Clk); #1;
        Rst = 1'b0;
        #1;
        sbq.delete();
        refMem[8] = saved;
        fwdValid = 1'b0;
        chk("mid_rst_we", 32'(MemWE), 32'd0);
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_done", 32'(Done), 32'd0);
        chk("mid_rst_ready", 32'(ReqReady), 32'd1);
        @(posedge Clk); @(posedge Clk); #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        chk("post_rst_ready", 32'(ReqReady), 32'd1);
        chk("post_rst_busy", 32'(Busy), 32'd0);
        chk("post_rst_mem", mem[8], 32'hCAFEF00D);

        // Randomized traffic over a small window, with aliasing high address bits.
        for (int n = 0; n < 300; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            int          pick;
            pick = int'($urandom_range(0, 9));
            sz = (pick < 3) ? 2'b00 : (pick < 6) ? 2'b01 : (pick < 9) ? 2'b10 : 2'b11;
            a = {$urandom_range(0, 1) == 1 ? 20'(($urandom_range(1, 255)) << 4) : 20'h0,
                 6'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if (sz == 2'b00 && $urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            if (sz == 2'b01 && $urandom_range(0, 7) != 0) a[0] = 1'b0;
            issue(sz, a, $urandom, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                ReqValid = 1'b0;
                @(posedge Clk); #1;
            end
        end
        ReqValid = 1'b0;
        drain();
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], refMem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
Read-modify-write store controller between the EX/MEM pipeline register and the single-port, word-addressed data memory. It accepts sw/sh/sb requests and issues the memory traffic for each. Sub-word stores read the target word, merge the register halfword or byte into the correct lane, and write the result back. Busy stalls the pipeline while a request is in flight.

Parameters:
ADDR_WIDTH, 10, word-address width of data memory; word index = Addr[ADDR_WIDTH+1:2]
READ_LATENCY, 1, cycles from MemRE to valid MemRdData (legal range 1..4)

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  reset, asynchronous, active-low
ReqValid  input  1  store request present
ReqReady  output  1  block can accept a request (high only in IDLE)
StoreSize  input  2  00=word, 01=half, 10=byte, 11=reserved
Addr  input  32  byte address
RegData  input  32  source register value
MemAddr  output  ADDR_WIDTH  memory word address
MemRE  output  1  memory read enable
MemWE  output  1  memory write enable
MemWrData  output  32  memory write data
MemRdData  input  32  memory read data
Busy  output  1  pipeline stall; high whenever state != IDLE
Done  output  1  one-cycle pulse, coincident with MemWE
AlignErr  output  1  one-cycle pulse on a misaligned or reserved request

Behaviour:
- Reset values: all outputs 0 except ReqReady=1; state=IDLE; capture registers cleared.
- States: IDLE, READ, WAIT, CAPTURE, WRITE, ERR.
- IDLE: accept when ReqValid&&ReqReady (cycle c0). Register Addr, StoreSize and RegData. Next state:
  - ERR if the request is illegal: word with Addr[1:0]!=0, half with Addr[0]=1, or StoreSize=11.
  - WRITE if word.
  - READ otherwise.
- READ (c1): MemRE=1, MemAddr=word index. If READ_LATENCY=1, go to CAPTURE; otherwise go to WAIT.
- WAIT: counter holds for READ_LATENCY-1 cycles, then goes to CAPTURE.
- CAPTURE (c1+READ_LATENCY): register MemRdData into the merge buffer. Go to WRITE.
- WRITE: MemWE=1, MemAddr=word index, MemWrData=merged word (full RegData for word stores), Done=1. Go to IDLE.
- ERR (c1): AlignErr=1, MemRE=MemWE=0. Go to IDLE.
- Latency, accept to write cycle:
  - word: 1 cycle.
  - half/byte: 2+READ_LATENCY cycles (3 at default).
  - No back-to-back accept: the next accept is earliest in the cycle after WRITE or ERR.
- Merge rules:
  - Half, Addr[1]=1: {RegData[15:0], Mem[15:0]}.
  - Half, Addr[1]=0: {Mem[31:16], RegData[15:0]}.
  - Byte: lane Addr[1:0]; lane 3=[31:24], lane 0=[7:0]; other lanes preserved.
- MemRE and MemWE are never high in the same cycle. Both are 0 outside READ and WRITE.
- Inputs are ignored while not in IDLE; ReqValid held high simply waits.
- Reset mid-operation: immediate (asynchronous) return to IDLE; MemWE/MemRE/Done/Busy drop to 0; the pending store is discarded and no partial write occurs.
- MemAddr uses only the low ADDR_WIDTH bits of the word index; higher address bits are ignored (wrap-around).

Optional Feature:
STORE_FWD_EN
- Defined:
  - A one-entry write buffer holds {valid, word index, data} of the last word written. Every WRITE updates it.
  - A half/byte accept that hits a valid entry with an equal word index skips READ/WAIT/CAPTURE and merges with the buffered data. WRITE follows in c1, so latency is 1.
  - Reset clears valid.
  - Correct only when this block is the sole writer of the memory.
- Undefined: no buffer; every sub-word store reads memory.

Decomposition:
- Package store_pkg:
  - StoreSize encodings SZ_WORD/SZ_HALF/SZ_BYTE/SZ_RSVD.
  - State enum.
  - Lane-merge function signature.
- One combinational sub-module, store_lane_merge, with inputs old word, RegData, size, Addr[1:0] and output the merged word. It is reused by the forwarding path.

Test Plan:
1. sw Addr=0x10, RegData=0xDEADBEEF -> c1: MemWE=1, MemAddr=4, MemWrData=0xDEADBEEF, Done=1; no MemRE.
2. sh Addr=0x12, RegData=0x0000ABCD, mem[4]=0x11223344 -> c1 MemRE, MemAddr=4; c3 MemWE with data 0xABCD3344; Busy high c1-c3.
3. sb Addr=0x11, RegData=0x000000EE, mem[4]=0x11223344 -> c3 write 0x1122EE44; repeat for lanes 0/2/3 -> 0x112233EE, 0x11EE3344, 0xEE223344.
4. sh Addr=0x13; also StoreSize=11 -> AlignErr pulse c1, no MemRE/MemWE, ReqReady=1 at c2.
5. sh accepted, Rst=0 at c2 -> MemWE never asserted; all outputs reset; after release ReqReady=1, Busy=0.
6. With STORE_FWD_EN: sw 0x10 0xDEADBEEF, then sh 0x10 RegData=0x1234 -> second store has no MemRE, writes 0xDEAD1234 one cycle after accept. Without the macro: MemRE is issued and the write lands at c3.
